// File: rtl/tdc_pkg.sv
// Shared types and default widths for the TDC decoder back end.
package tdc_pkg;

  localparam int NTAPS_DEF       = 64;
  localparam int FINE_W_DEF      = 7;
  localparam int COARSE_W_DEF    = 16;
  localparam int DEAD_CYCLES_DEF = 2;
  localparam int FIFO_DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DEAD    = 2'd2
  } state_t;

  // Default-width view of one FIFO entry, ordered as stored: {coarse, fine, sat}.
  typedef struct packed {
    logic [COARSE_W_DEF-1:0] coarse;
    logic [FINE_W_DEF-1:0]   fine;
    logic                    sat;
  } timestamp_t;

endpackage

// File: rtl/tdc_fifo.sv
// Synchronous timestamp FIFO; pointers carry an extra MSB to tell full from empty.
module tdc_fifo
  import tdc_pkg::*;
#(
  parameter int WIDTH = COARSE_W_DEF + FINE_W_DEF + 1,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the read port is masked while empty so stale data never shows.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tdc_decoder.sv
// TDC back end: tap sampling, hit FSM with dead time, popcount fine code,
// coarse counter and output FIFO with sticky overflow.
module tdc_decoder
  import tdc_pkg::*;
#(
  parameter int NTAPS       = NTAPS_DEF,
  parameter int FINE_W      = FINE_W_DEF,
  parameter int COARSE_W    = COARSE_W_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       iRst,
  input  logic                       iEnable,
  input  logic [NTAPS-1:0]           iTaps,
  input  logic                       iReady,
  input  logic                       iClrOvf,
  output logic                       oValid,
  output logic [COARSE_W+FINE_W-1:0] oTimestamp,
  output logic                       oSat,
  output logic                       oOverflow,
  output logic                       oBusy
);

  localparam int HALF   = NTAPS / 2;
  localparam int HALF_W = $clog2(HALF) + 1;
  localparam int DW     = COARSE_W + FINE_W + 1;
  localparam int CNT_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  logic [NTAPS-1:0]    taps_q;
  logic [COARSE_W-1:0] coarse;
  logic [COARSE_W-1:0] coarse_q;
  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    dead_cnt;
  logic [CNT_W-1:0]    dead_cnt_nxt;
  logic                busy_q;
  logic                hit;

  logic [HALF_W-1:0]   lo_cnt, hi_cnt;
  logic [HALF_W-1:0]   s1_lo, s1_hi;
  logic [COARSE_W-1:0] s1_coarse, s2_coarse;
  logic                s1_valid, s2_valid;
  logic [FINE_W-1:0]   fine_sum, s2_fine;
  logic                s2_sat;

  logic [DW-1:0]       head;
  logic                fifo_empty;
  logic                fifo_drop;
  logic                ovf_q;

  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      taps_q   <= '0;
      coarse_q <= '0;
      coarse   <= '0;
    end else begin
      taps_q   <= iTaps;
      coarse_q <= coarse;
      if (iEnable) coarse <= coarse + 1'b1;
    end
  end

  assign hit = (state == IDLE) && iEnable && taps_q[0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    dead_cnt_nxt = dead_cnt;
    unique case (state)
      IDLE:    if (hit) state_nxt = CAPTURE;
      CAPTURE: begin
        state_nxt    = DEAD;
        dead_cnt_nxt = CNT_W'(DEAD_CYCLES - 1);
      end
      DEAD: begin
        // Leave only once the input stage has cleared the chain head.
        if (dead_cnt != '0)  dead_cnt_nxt = dead_cnt - 1'b1;
        else if (!taps_q[0]) state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      state    <= IDLE;
      dead_cnt <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      dead_cnt <= dead_cnt_nxt;
      busy_q   <= (state_nxt != IDLE);
    end
  end

  // Two half-width ones counters; counting rather than edge-finding absorbs bubbles.
  always_comb begin
    lo_cnt = '0;
    hi_cnt = '0;
    for (int i = 0; i < HALF; i++) begin
      lo_cnt = lo_cnt + HALF_W'(taps_q[i]);
      hi_cnt = hi_cnt + HALF_W'(taps_q[HALF+i]);
    end
  end

  assign fine_sum = FINE_W'(s1_lo) + FINE_W'(s1_hi);

  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst) begin
      s1_valid  <= 1'b0;
      s1_lo     <= '0;
      s1_hi     <= '0;
      s1_coarse <= '0;
      s2_valid  <= 1'b0;
      s2_fine   <= '0;
      s2_sat    <= 1'b0;
      s2_coarse <= '0;
    end else begin
      s1_valid  <= hit;
      s1_lo     <= lo_cnt;
      s1_hi     <= hi_cnt;
      s1_coarse <= coarse_q;
      s2_valid  <= s1_valid;
      s2_fine   <= fine_sum;
      s2_sat    <= (fine_sum == FINE_W'(NTAPS));
      s2_coarse <= s1_coarse;
    end
  end

  tdc_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (iRst),
    .push  (s2_valid),
    .wdata ({s2_coarse, s2_fine, s2_sat}),
    .pop   (iReady),
    .rdata (head),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // A drop in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge clk or negedge iRst) begin
    if (!iRst)          ovf_q <= 1'b0;
    else if (fifo_drop) ovf_q <= 1'b1;
    else if (iClrOvf)   ovf_q <= 1'b0;
  end

  assign oValid               = !fifo_empty;
  assign {oTimestamp, oSat}   = head;
  assign oOverflow            = ovf_q;
  assign oBusy                = busy_q;

endmodule

// File: tb/tb_tdc_decoder.sv
// Directed bench for tdc_decoder: expected timestamps queued at stimulus time,
// compared in arrival order whenever the consumer accepts one.
module tb_tdc_decoder;
  import tdc_pkg::*;

  logic        clk;
  logic        iRst;
  logic        iEnable;
  logic [63:0] iTaps;
  logic        iReady;
  logic        iClrOvf;
  logic        oValid;
  logic [22:0] oTimestamp;
  logic        oSat;
  logic        oOverflow;
  logic        oBusy;

  timestamp_t  sb[$];
  logic [15:0] mc;
  int          n_checks;
  int          n_pass;
  int          n_fail;

  tdc_decoder dut (
    .clk        (clk),
    .iRst       (iRst),
    .iEnable    (iEnable),
    .iTaps      (iTaps),
    .iReady     (iReady),
    .iClrOvf    (iClrOvf),
    .oValid     (oValid),
    .oTimestamp (oTimestamp),
    .oSat       (oSat),
    .oOverflow  (oOverflow),
    .oBusy      (oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: score any transfer the coming edge will make, then advance the coarse model.
  task automatic tick();
    timestamp_t e;
    @(negedge clk);
    if (oValid && iReady) begin
      if (sb.size() == 0) begin
        check("spurious_entry", 64'(oValid), 64'(1'b0));
      end else begin
        e = sb.pop_front();
        check("ts_coarse", 64'(oTimestamp[22:7]), 64'(e.coarse));
        check("ts_fine", 64'(oTimestamp[6:0]), 64'(e.fine));
        check("ts_sat", 64'(oSat), 64'(e.sat));
      end
    end
    @(posedge clk);
    if (!iRst)        mc = '0;
    else if (iEnable) mc = mc + 16'd1;
    #1;
  endtask

  task automatic hit(input logic [63:0] taps, input logic [6:0] fine, input logic sat,
                     input bit expect_push);
    timestamp_t e;
    iTaps = taps;
    if (expect_push) begin
      e.coarse = mc;
      e.fine   = fine;
      e.sat    = sat;
      sb.push_back(e);
    end
    tick();
    iTaps = '0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
    repeat (3) tick();
    check(tag, 64'(sb.size()), 64'd0);
    check({tag, "_empty"}, 64'(oValid), 64'(1'b0));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    mc       = '0;
    iRst     = 1'b0;
    iEnable  = 1'b0;
    iTaps    = '0;
    iReady   = 1'b0;
    iClrOvf  = 1'b0;

    repeat (3) tick();
    check("rst_valid", 64'(oValid), 64'(1'b0));
    check("rst_ts", 64'(oTimestamp), 64'd0);
    check("rst_sat", 64'(oSat), 64'(1'b0));
    check("rst_ovf", 64'(oOverflow), 64'(1'b0));
    check("rst_busy", 64'(oBusy), 64'(1'b0));

    iRst    = 1'b1;
    iEnable = 1'b1;
    iReady  = 1'b1;

    // Thermometer of 8 at coarse 100, with latency probe.
    for (int i = 0; i < 200 && mc != 16'd100; i++) tick();
    hit(64'h0000_0000_0000_00FF, 7'd8, 1'b0, 1'b1);
    check("lat_n0", 64'(oValid), 64'(1'b0));
    tick();
    check("lat_n1", 64'(oValid), 64'(1'b0));
    tick();
    check("lat_n2", 64'(oValid), 64'(1'b0));
    tick();
    check("lat_n3", 64'(oValid), 64'(1'b1));
    check("lat_coarse", 64'(oTimestamp[22:7]), 64'd100);
    drain("drain_therm8");

    // Bubble at bit 2 and a fully saturated chain.
    hit(64'h0000_0000_0000_00FB, 7'd7, 1'b0, 1'b1);
    drain("drain_bubble");
    hit(64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b1, 1'b1);
    drain("drain_sat");

    // Chain head stuck for 5 samples: one entry, busy until it clears.
    iTaps = 64'h1;
    begin
      timestamp_t e;
      e.coarse = mc;
      e.fine   = 7'd1;
      e.sat    = 1'b0;
      sb.push_back(e);
    end
    repeat (5) tick();
    iTaps = '0;
    check("busy_stuck", 64'(oBusy), 64'(1'b1));
    tick();
    check("busy_clearing", 64'(oBusy), 64'(1'b1));
    tick();
    check("busy_released", 64'(oBusy), 64'(1'b0));
    drain("drain_stuck");

    // Enable low blocks new hits.
    iEnable = 1'b0;
    hit(64'h0000_0000_0000_000F, 7'd4, 1'b0, 1'b0);
    repeat (4) tick();
    check("dis_busy", 64'(oBusy), 64'(1'b0));
    check("dis_valid", 64'(oValid), 64'(1'b0));
    iEnable = 1'b1;
    tick();

    // Overflow: five hits into a stalled consumer.
    iReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) check("ovf_before", 64'(oOverflow), 64'(1'b0));
      hit(64'(64'h3F >> k), 7'(6 - k), 1'b0, (k < 4));
      repeat (5) tick();
    end
    check("ovf_set", 64'(oOverflow), 64'(1'b1));
    check("ovf_full_valid", 64'(oValid), 64'(1'b1));
    iClrOvf = 1'b1;
    tick();
    iClrOvf = 1'b0;
    check("ovf_clear", 64'(oOverflow), 64'(1'b0));
    iReady = 1'b1;
    drain("drain_ovf");

    // Coarse wrap: hit one cycle after the counter reads 0xFFFF.
    for (int i = 0; i < 70000 && mc != 16'hFFFF; i++) tick();
    tick();
    hit(64'h0000_0000_0000_0003, 7'd2, 1'b0, 1'b1);
    drain("drain_wrap");

    // Reset between detect and push discards the entry and restarts the counter.
    hit(64'h0000_0000_0000_000F, 7'd4, 1'b0, 1'b0);
    tick();
    iRst = 1'b0;
    tick();
    check("rst_mid_valid", 64'(oValid), 64'(1'b0));
    tick();
    check("rst_mid_busy", 64'(oBusy), 64'(1'b0));
    check("rst_mid_valid2", 64'(oValid), 64'(1'b0));
    iRst = 1'b1;
    hit(64'h0000_0000_0000_001F, 7'd5, 1'b0, 1'b1);
    drain("drain_post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
